// File: rtl/toy_pkg.sv
// ============================================================================
// toy_pkg -- shared opcode, ALU, PC-select and control-word field constants
// Rev 1.0
// ============================================================================
`default_nettype none

package toy_pkg;

  typedef enum logic [3:0] {
    OP_HLT  = 4'h0,
    OP_LDA  = 4'h1,
    OP_STA  = 4'h2,
    OP_ADD  = 4'h3,
    OP_ADC  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_OR   = 4'h7,
    OP_XOR  = 4'h8,
    OP_JC   = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_MOVT = 4'hC,
    OP_JMP  = 4'hD,
    OP_JZ   = 4'hE,
    OP_JMPI = 4'hF
  } opcode_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_ADC  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_NOTA = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_MEM  = 2'b01;
  localparam logic [1:0] PC_ADDR = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;

  localparam int CTRL_W            = 12;
  localparam int CTRL_PC_LSB       = 0;
  localparam int CTRL_PC_MSB       = 1;
  localparam int CTRL_A_WE         = 2;
  localparam int CTRL_A_SRC        = 3;
  localparam int CTRL_T_WE         = 4;
  localparam int CTRL_ALU_LSB      = 5;
  localparam int CTRL_ALU_MSB      = 7;
  localparam int CTRL_MEM_WE       = 8;
  localparam int CTRL_MEM_ADDR_SEL = 9;
  localparam int CTRL_MEM_WDATA_SEL = 10;
  localparam int CTRL_FLAG_WE      = 11;

  // Arithmetic/logic opcodes ADD..XOR are contiguous and map onto ALU_ADD..ALU_XOR.
  function automatic logic [2:0] alu_op_of(input logic [3:0] op);
    logic [3:0] delta;
    delta = op - 4'(OP_ADD);
    return delta[2:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/toy_alu.sv
// ============================================================================
// toy_alu -- 16-bit combinational ALU with registered carry/zero flags
// Rev 1.0
// ============================================================================
`default_nettype none

module toy_alu
  import toy_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  alu_op,
  input  logic        flag_we,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        carry,
  output logic        zero
);

  logic [16:0] sum;
  logic        carry_next;

  always_comb begin
    sum        = '0;
    result     = '0;
    carry_next = carry;
    case (alu_op)
      ALU_ADD: begin
        sum        = {1'b0, a} + {1'b0, b};
        result     = sum[15:0];
        carry_next = sum[16];
      end
      ALU_ADC: begin
        sum        = {1'b0, a} + {1'b0, b} + {16'b0, carry};
        result     = sum[15:0];
        carry_next = sum[16];
      end
      // A 17-bit subtract leaves bit 16 set exactly when a borrow occurs.
      ALU_SUB: begin
        sum        = {1'b0, a} - {1'b0, b};
        result     = sum[15:0];
        carry_next = sum[16];
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOTA: result = ~a;
      ALU_PASS: result = b;
      default:  result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (flag_we) begin
      carry <= carry_next;
      zero  <= (result == 16'h0000);
    end
  end

endmodule

`default_nettype wire

// File: rtl/toy_ctrl_decode.sv
// ============================================================================
// toy_ctrl_decode -- combinational control-word decoder from opcode and flags
// Rev 1.0
// ============================================================================
`default_nettype none

module toy_ctrl_decode
  import toy_pkg::*;
(
  input  logic [3:0]        opcode,
  input  logic              carry,
  input  logic              zero,
  output logic [CTRL_W-1:0] ctrl
);

  always_comb begin
    ctrl = '0;
    case (opcode)
      OP_HLT:  ctrl[CTRL_PC_MSB:CTRL_PC_LSB] = PC_HOLD;
      OP_LDA: begin
        ctrl[CTRL_A_WE]  = 1'b1;
        ctrl[CTRL_A_SRC] = 1'b1;
      end
      OP_STA:  ctrl[CTRL_MEM_WE] = 1'b1;
      OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        ctrl[CTRL_A_WE]                  = 1'b1;
        ctrl[CTRL_FLAG_WE]               = 1'b1;
        ctrl[CTRL_ALU_MSB:CTRL_ALU_LSB]  = alu_op_of(opcode);
      end
      OP_JC:   ctrl[CTRL_PC_MSB:CTRL_PC_LSB] = carry ? PC_ADDR : PC_INC;
      OP_LDI: begin
        ctrl[CTRL_A_WE]         = 1'b1;
        ctrl[CTRL_A_SRC]        = 1'b1;
        ctrl[CTRL_MEM_ADDR_SEL] = 1'b1;
      end
      OP_STI: begin
        ctrl[CTRL_MEM_WE]        = 1'b1;
        ctrl[CTRL_MEM_ADDR_SEL]  = 1'b1;
        ctrl[CTRL_MEM_WDATA_SEL] = 1'b1;
      end
      OP_MOVT: ctrl[CTRL_T_WE] = 1'b1;
      OP_JMP:  ctrl[CTRL_PC_MSB:CTRL_PC_LSB] = PC_ADDR;
      OP_JZ:   ctrl[CTRL_PC_MSB:CTRL_PC_LSB] = zero ? PC_ADDR : PC_INC;
      OP_JMPI: ctrl[CTRL_PC_MSB:CTRL_PC_LSB] = PC_MEM;
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/toy_dmem.sv
// ============================================================================
// toy_dmem -- 4096x16 data memory, asynchronous read, synchronous write
// Rev 1.0
// ============================================================================
`default_nettype none

module toy_dmem (
  input  logic        clk,
  input  logic        we,
  input  logic [11:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);

  logic [15:0] mem [4096];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Combinational read sees the pre-edge word during a write cycle.
  assign rdata = mem[addr];

endmodule

`default_nettype wire

// File: rtl/toy_datapath_core.sv
// ============================================================================
// toy_datapath_core -- decoder, ALU/flags and data memory of the toy CPU
// Rev 1.0
// ============================================================================
`default_nettype none

module toy_datapath_core
  import toy_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        opcode,
  input  logic [11:0]       addr,
  input  logic [15:0]       acc,
  input  logic [15:0]       tmp,
  output logic [CTRL_W-1:0] ctrl,
  output logic [15:0]       mem_data,
  output logic [15:0]       alu_out,
  output logic              carry,
  output logic              zero
);

  logic [CTRL_W-1:0] dec_ctrl;
  logic              mem_we;
  logic [11:0]       mem_addr;
  logic [15:0]       mem_wdata;

  toy_ctrl_decode u_decode (
    .opcode (opcode),
    .carry  (carry),
    .zero   (zero),
    .ctrl   (dec_ctrl)
  );

  // Memory writes are suppressed while reset is asserted.
  assign mem_we = dec_ctrl[CTRL_MEM_WE] & rst_n;

  always_comb begin
    ctrl              = dec_ctrl;
    ctrl[CTRL_MEM_WE] = mem_we;
  end

  assign mem_addr  = dec_ctrl[CTRL_MEM_ADDR_SEL]  ? acc[11:0] : addr;
  assign mem_wdata = dec_ctrl[CTRL_MEM_WDATA_SEL] ? tmp       : acc;

  toy_dmem u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_data)
  );

  toy_alu u_alu (
    .clk     (clk),
    .rst_n   (rst_n),
    .alu_op  (dec_ctrl[CTRL_ALU_MSB:CTRL_ALU_LSB]),
    .flag_we (dec_ctrl[CTRL_FLAG_WE]),
    .a       (acc),
    .b       (mem_data),
    .result  (alu_out),
    .carry   (carry),
    .zero    (zero)
  );

endmodule

`default_nettype wire

// File: tb/tb_toy_datapath_core.sv
// ============================================================================
// tb_toy_datapath_core -- directed and randomized checks against a reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_toy_datapath_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  opcode;
  logic [11:0] addr;
  logic [15:0] acc;
  logic [15:0] tmp;
  logic [11:0] ctrl;
  logic [15:0] mem_data;
  logic [15:0] alu_out;
  logic        carry;
  logic        zero;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_mem [4096];
  logic        ref_c;
  logic        ref_z;

  toy_datapath_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .opcode   (opcode),
    .addr     (addr),
    .acc      (acc),
    .tmp      (tmp),
    .ctrl     (ctrl),
    .mem_data (mem_data),
    .alu_out  (alu_out),
    .carry    (carry),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  // Control word built field by field from the instruction table.
  function automatic logic [11:0] exp_ctrl(input logic [3:0] op, input logic c,
                                           input logic z, input logic rn);
    logic [1:0] pc;
    logic [2:0] alu;
    logic a_we, a_src, t_we, mw, mas, mws, fw;
    pc = 2'd0; alu = 3'd0;
    a_we = 0; a_src = 0; t_we = 0; mw = 0; mas = 0; mws = 0; fw = 0;
    if (op >= 4'd3 && op <= 4'd8) begin
      a_we = 1; fw = 1;
      alu = 3'(op - 4'd3);
    end
    case (op)
      4'd0:  pc = 2'd3;
      4'd1:  begin a_we = 1; a_src = 1; end
      4'd2:  mw = 1;
      4'd9:  pc = c ? 2'd2 : 2'd0;
      4'd10: begin a_we = 1; a_src = 1; mas = 1; end
      4'd11: begin mw = 1; mas = 1; mws = 1; end
      4'd12: t_we = 1;
      4'd13: pc = 2'd2;
      4'd14: pc = z ? 2'd2 : 2'd0;
      4'd15: pc = 2'd1;
      default: ;
    endcase
    if (!rn) mw = 0;
    return {fw, mws, mas, mw, alu, t_we, a_src, a_we, pc};
  endfunction

  function automatic void exp_alu(input logic [2:0] op, input logic [15:0] a,
                                  input logic [15:0] b, input logic cin,
                                  output logic [15:0] r, output logic cout);
    logic [31:0] s;
    s = 32'd0;
    cout = cin;
    case (op)
      3'd0: begin s = 32'(a) + 32'(b); r = s[15:0]; cout = (s > 32'hFFFF); end
      3'd1: begin s = 32'(a) + 32'(b) + 32'(cin); r = s[15:0]; cout = (s > 32'hFFFF); end
      3'd2: begin r = a - b; cout = (a < b); end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = ~a;
      default: r = b;
    endcase
  endfunction

  function automatic logic [15:0] exp_read();
    logic [11:0] c;
    c = exp_ctrl(opcode, ref_c, ref_z, rst_n);
    return ref_mem[c[9] ? acc[11:0] : addr];
  endfunction

  function automatic logic [15:0] exp_aluout();
    logic [11:0] c;
    logic [15:0] r;
    logic co;
    c = exp_ctrl(opcode, ref_c, ref_z, rst_n);
    exp_alu(c[7:5], acc, exp_read(), ref_c, r, co);
    return r;
  endfunction

  // Advance one rising edge and apply its architectural effects to the model.
  task automatic clock_edge();
    logic [11:0] c;
    logic [11:0] ra;
    logic [15:0] r;
    logic co;
    c  = exp_ctrl(opcode, ref_c, ref_z, rst_n);
    ra = c[9] ? acc[11:0] : addr;
    exp_alu(c[7:5], acc, ref_mem[ra], ref_c, r, co);
    @(posedge clk);
    if (!rst_n) begin
      ref_c = 1'b0;
      ref_z = 1'b0;
    end else if (c[11]) begin
      ref_c = co;
      ref_z = (r == 16'h0000);
    end
    if (c[8]) ref_mem[ra] = c[10] ? tmp : acc;
    #1;
  endtask

  task automatic store(input logic [11:0] a, input logic [15:0] d);
    rst_n = 1'b1; opcode = 4'h2; addr = a; acc = d;
    clock_edge();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = 4'h0; addr = '0; acc = '0; tmp = '0;
    clock_edge();
    clock_edge();
    checks++;
    if (carry !== 1'b0) begin errors++; $display("FAIL reset_carry got %b want 0", carry); end
    checks++;
    if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", zero); end
    store(12'h020, 16'h1111);
    rst_n = 1'b0; opcode = 4'h2; addr = 12'h020; acc = 16'h2222; #1;
    checks++;
    if (ctrl[8] !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", ctrl[8]); end
    clock_edge();
    rst_n = 1'b1; opcode = 4'h1; #1;
    checks++;
    if (mem_data !== 16'h1111) begin
      errors++; $display("FAIL reset_no_write got %h want 1111", mem_data);
    end
  endtask

  task automatic test_sta_lda();
    store(12'h010, 16'h1234);
    opcode = 4'h1; acc = 16'h0000; #1;
    checks++;
    if (mem_data !== 16'h1234) begin errors++; $display("FAIL lda_data got %h want 1234", mem_data); end
    checks++;
    if (ctrl[3:2] !== 2'b11) begin errors++; $display("FAIL lda_ctrl got %b want 11", ctrl[3:2]); end
  endtask

  task automatic test_add_overflow();
    store(12'h005, 16'hFFFF);
    opcode = 4'h3; addr = 12'h005; acc = 16'h0001; #1;
    checks++;
    if (alu_out !== 16'h0000) begin errors++; $display("FAIL add_ovf_out got %h want 0000", alu_out); end
    clock_edge();
    checks++;
    if (carry !== 1'b1 || zero !== 1'b1) begin
      errors++; $display("FAIL add_ovf_flags got c=%b z=%b want c=1 z=1", carry, zero);
    end
  endtask

  task automatic test_sub_borrow();
    store(12'h006, 16'h0003);
    opcode = 4'h5; addr = 12'h006; acc = 16'h0002; #1;
    checks++;
    if (alu_out !== 16'hFFFF) begin errors++; $display("FAIL sub_out got %h want ffff", alu_out); end
    clock_edge();
    checks++;
    if (carry !== 1'b1 || zero !== 1'b0) begin
      errors++; $display("FAIL sub_flags got c=%b z=%b want c=1 z=0", carry, zero);
    end
  endtask

  task automatic test_reset_dominates();
    opcode = 4'h3; addr = 12'h005; acc = 16'h0001;
    clock_edge();
    rst_n = 1'b0;
    clock_edge();
    checks++;
    if (carry !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL reset_dominates got c=%b z=%b want c=0 z=0", carry, zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_branches();
    opcode = 4'h3; addr = 12'h005; acc = 16'h0001;
    clock_edge();
    opcode = 4'hE; #1;
    checks++;
    if (ctrl[1:0] !== 2'b10) begin errors++; $display("FAIL jz_taken got %b want 10", ctrl[1:0]); end
    opcode = 4'h8; addr = 12'h005; acc = 16'h0001;
    clock_edge();
    opcode = 4'hE; #1;
    checks++;
    if (ctrl[1:0] !== 2'b00) begin errors++; $display("FAIL jz_not_taken got %b want 00", ctrl[1:0]); end
    opcode = 4'h9; #1;
    checks++;
    if (ctrl[1:0] !== 2'b10) begin errors++; $display("FAIL jc_taken got %b want 10", ctrl[1:0]); end
    opcode = 4'h0; #1;
    checks++;
    if (ctrl[1:0] !== 2'b11) begin errors++; $display("FAIL hlt_hold got %b want 11", ctrl[1:0]); end
    store(12'h007, 16'h0ABC);
    opcode = 4'hF; addr = 12'h007; #1;
    checks++;
    if (ctrl[1:0] !== 2'b01 || mem_data[11:0] !== 12'hABC) begin
      errors++; $display("FAIL jmpi got pc=%b data=%h want pc=01 data=abc", ctrl[1:0], mem_data[11:0]);
    end
  endtask

  task automatic test_sti_ldi();
    rst_n = 1'b1; opcode = 4'hB; addr = 12'h000; acc = 16'h0020; tmp = 16'h5A5A;
    clock_edge();
    opcode = 4'hA; #1;
    checks++;
    if (mem_data !== 16'h5A5A) begin errors++; $display("FAIL ldi_data got %h want 5a5a", mem_data); end
  endtask

  task automatic test_random();
    logic [11:0] ec;
    logic [15:0] ed, eo;
    logic [31:0] rnd;
    for (int i = 0; i < 32; i++) store(12'(i), 16'($urandom));
    for (int i = 0; i < 400; i++) begin
      rnd    = $urandom;
      rst_n  = ($urandom_range(0, 19) != 0);
      opcode = rnd[3:0];
      addr   = 12'($urandom_range(0, 31));
      acc    = 16'($urandom);
      acc[11:5] = '0;
      tmp    = 16'($urandom);
      #1;
      ec = exp_ctrl(opcode, ref_c, ref_z, rst_n);
      ed = exp_read();
      eo = exp_aluout();
      checks++;
      if (ctrl !== ec) begin
        errors++; $display("FAIL rand_ctrl i=%0d op=%h got %h want %h", i, opcode, ctrl, ec);
      end
      checks++;
      if (mem_data !== ed) begin
        errors++; $display("FAIL rand_mem_data i=%0d op=%h got %h want %h", i, opcode, mem_data, ed);
      end
      checks++;
      if (alu_out !== eo) begin
        errors++; $display("FAIL rand_alu_out i=%0d op=%h got %h want %h", i, opcode, alu_out, eo);
      end
      clock_edge();
      checks++;
      if (carry !== ref_c || zero !== ref_z) begin
        errors++; $display("FAIL rand_flags i=%0d op=%h got c=%b z=%b want c=%b z=%b",
                           i, opcode, carry, zero, ref_c, ref_z);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    ref_c = 1'b0;
    ref_z = 1'b0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 16'h0000;
    rst_n = 1'b0; opcode = '0; addr = '0; acc = '0; tmp = '0;
    #1;
    test_reset();
    test_sta_lda();
    test_add_overflow();
    test_sub_borrow();
    test_reset_dominates();
    test_branches();
    test_sti_ldi();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
